// File: rtl/add_result_writer_pkg.sv
// Shared types and constants for the ADD result writer: lane sizes, writer FSM
// state encodings and a ceiling-divide helper for vector counts.
package add_result_writer_pkg;

    localparam int INT8_SIZE  = 8;
    localparam int INT32_SIZE = 32;
    localparam int WR_STATE_W = 2;

    typedef enum logic [WR_STATE_W-1:0] {
        WR_IDLE = 2'd0,
        WR_RUN  = 2'd1,
        WR_DONE = 2'd2
    } wr_state_t;

    // Number of d-wide vectors needed to cover n elements.
    function automatic logic [31:0] ceil_div(input logic [31:0] n, input logic [31:0] d);
        return (n / d) + {31'd0, (n % d) != 32'd0};
    endfunction

endpackage

// File: rtl/add_result_writer_result_fifo.sv
// Synchronous result FIFO. The head entry is read straight out of the storage
// registers, so a vector pushed in cycle N is visible at the head in cycle N+1.
module add_result_writer_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; readers only look at it while non-empty.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/add_result_writer.sv
// Absorbs the un-stallable ADD result stream, buffers it and writes it to SRAM.
// Optional feature macro: ADD_RESULT_WRITER_PERF_EN adds perf_stall_cycles.
module add_result_writer
    import add_result_writer_pkg::*;
#(
    parameter int MAX_VECTOR_SIZE = 8,
    parameter int ADDR_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    input  logic [INT32_SIZE-1:0]                num_elems,
    input  logic                                 issue_i,
    input  logic                                 valid_in,
    input  logic [INT8_SIZE*MAX_VECTOR_SIZE-1:0] data_in,
    output logic                                 stall_o,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [INT8_SIZE*MAX_VECTOR_SIZE-1:0] mem_wdata,
    output logic [MAX_VECTOR_SIZE-1:0]           mem_wstrb,
    input  logic                                 mem_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overflow_err,
`ifdef ADD_RESULT_WRITER_PERF_EN
    output logic [31:0]                          perf_stall_cycles,
`endif
    output logic [WR_STATE_W-1:0]                dbg_state
);
    localparam int DATA_W = INT8_SIZE * MAX_VECTOR_SIZE;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W = CNT_W + 1;
    localparam int LANE_W = $clog2(MAX_VECTOR_SIZE);

    wr_state_t           r_state;
    wr_state_t           w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]         r_rem;
    logic [31:0]         r_vec_left;
    logic [CRED_W-1:0]   r_inflight;
    logic                r_stall;
    logic                r_overflow;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [DATA_W-1:0]   w_fifo_rdata;
    logic                w_we;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_last;
    logic                w_start;
    logic [CRED_W-1:0]   w_credit_sum;
    logic [MAX_VECTOR_SIZE-1:0] w_ones;
    logic [MAX_VECTOR_SIZE-1:0] w_strb;

    add_result_writer_result_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (data_in),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign w_start = (r_state == WR_IDLE) && start;
    assign w_we    = (r_state == WR_RUN) && !w_fifo_empty;
    assign w_pop   = w_we && mem_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push  = valid_in && (r_state == WR_RUN) && (r_vec_left != 32'd0)
                     && (!w_fifo_full || w_pop);
    assign w_drop  = valid_in && !w_push;
    assign w_last  = (r_rem <= 32'(MAX_VECTOR_SIZE));

    assign w_ones  = '1;
    assign w_strb  = (r_rem >= 32'(MAX_VECTOR_SIZE)) ? w_ones
                                                     : ~(w_ones << r_rem[LANE_W-1:0]);
    assign w_credit_sum = CRED_W'(w_fifo_count) + r_inflight;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WR_IDLE: if (start) w_next_state = (num_elems == '0) ? WR_DONE : WR_RUN;
            WR_RUN:  if (w_pop && w_last) w_next_state = WR_DONE;
            WR_DONE: w_next_state = WR_IDLE;
            default: w_next_state = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= WR_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_vec_left <= '0;
            r_inflight <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_stall <= (w_credit_sum >= CRED_W'(FIFO_DEPTH - 1));

            case ({issue_i, valid_in})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            if (w_start) begin
                r_addr     <= base_addr;
                r_rem      <= num_elems;
                r_vec_left <= ceil_div(num_elems, 32'(MAX_VECTOR_SIZE));
                r_overflow <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_addr <= r_addr + 1'b1;
                    r_rem  <= w_last ? 32'd0 : r_rem - 32'(MAX_VECTOR_SIZE);
                end
                if (w_push) r_vec_left <= r_vec_left - 32'd1;
            end
            // A drop in the start cycle is still reported for the new job.
            if (w_drop) r_overflow <= 1'b1;
        end
    end

`ifdef ADD_RESULT_WRITER_PERF_EN
    logic [31:0] r_perf;

    // One increment per cycle in which either back-pressure source is active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf <= '0;
        end else if (w_start) begin
            r_perf <= '0;
        end else if ((w_we && !mem_ready) || r_stall) begin
            if (r_perf != 32'hFFFF_FFFF) r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf;
`endif

    assign stall_o      = r_stall;
    assign mem_we       = w_we;
    assign mem_addr     = w_we ? r_addr : '0;
    assign mem_wdata    = w_we ? w_fifo_rdata : '0;
    assign mem_wstrb    = w_we ? w_strb : '0;
    assign busy         = (r_state != WR_IDLE);
    assign done         = (r_state == WR_DONE);
    assign overflow_err = r_overflow;
    assign dbg_state    = r_state;

endmodule
